// File: rtl/package_settings.sv
// Project-wide data-path settings shared by the pulse-processing blocks.
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/v15_peak_parameters.sv
// Defaults, FSM state encoding and event record for the v15 peak detector.
package v15_peak_parameters;
  import package_settings::*;

  localparam int DEFAULT_HOLDOFF_CYCLES = 16;
  localparam int DEFAULT_FIFO_DEPTH     = 4;
  localparam int DEFAULT_TIME_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISE    = 2'd1,
    ST_HOLDOFF = 2'd2
  } peak_state_t;

  // Event record at default timestamp width; the top re-declares it at its own width.
  typedef struct packed {
    logic [SIZE_FILTER_DATA-1:0]   amplitude;
    logic [DEFAULT_TIME_WIDTH-1:0] timestamp;
  } peak_event_t;
endpackage

// File: rtl/v15_event_fifo.sv
// Event buffer with a registered head: push/full write side, valid/ready read side.
module v15_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("v15_event_fifo: DEPTH must be a power of two of at least 2");
  end

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [PTR_W:0]   count_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Next head bypasses the memory when the push lands in the slot about to become head.
  always_comb begin
    pop_s         = out_valid_r && out_ready;
    full_s        = (count_r == FULL_COUNT);
    wr_en_s       = push && (!full_s || pop_s);
    rd_ptr_next_s = pop_s ? (rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1}) : rd_ptr_r;
    count_next_s  = count_r + (PTR_W + 1)'(wr_en_s) - (PTR_W + 1)'(pop_s);
    if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {(PTR_W + 1){1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != {(PTR_W + 1){1'b0}});
      if (count_next_s != {(PTR_W + 1){1'b0}}) begin
        out_data_r <= head_next_s;
      end
    end
  end

  assign full      = full_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
endmodule

// File: rtl/v15_peak_detector.sv
// Threshold-triggered peak detector: tracks each pulse maximum and its first
// timestamp, then queues {peak, time} events behind a dead-time window.
module v15_peak_detector
  import package_settings::*;
  import v15_peak_parameters::*;
#(
  parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIME_WIDTH     = DEFAULT_TIME_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [SIZE_FILTER_DATA-1:0] out_amplitude,
  output logic [TIME_WIDTH-1:0]       out_time,
  output logic [7:0]                  dropped_count,
  output logic                        busy
);
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("v15_peak_detector: HOLDOFF_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic [SIZE_FILTER_DATA-1:0] amplitude;
    logic [TIME_WIDTH-1:0]       timestamp;
  } event_t;

  peak_state_t                 state_r;
  peak_state_t                 state_next_s;
  logic [TIME_WIDTH-1:0]       ts_r;
  logic [SIZE_FILTER_DATA-1:0] peak_r;
  logic [TIME_WIDTH-1:0]       peak_time_r;
  logic [HOLD_W-1:0]           holdoff_r;
  logic                        busy_r;
  logic [7:0]                  dropped_r;

  logic                        at_thr_s;
  logic                        capture_s;
  logic                        push_s;
  logic                        drop_s;
  logic                        fifo_full_s;
  event_t                      push_event_s;
  event_t                      head_event_s;

  assign at_thr_s     = (filter_data >= threshold);
  assign push_event_s = {peak_r, peak_time_r};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    state_next_s = at_thr_s ? ST_RISE : ST_IDLE;
      ST_RISE:    state_next_s = at_thr_s ? ST_RISE : ST_HOLDOFF;
      ST_HOLDOFF: state_next_s = (holdoff_r == {HOLD_W{1'b0}}) ? ST_IDLE : ST_HOLDOFF;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Strict greater-than in RISE keeps the earliest sample of a flat top.
  always_comb begin
    capture_s = 1'b0;
    push_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        capture_s = at_thr_s;
      end
      ST_RISE: begin
        capture_s = at_thr_s && (filter_data > peak_r);
        push_s    = !at_thr_s;
      end
      ST_HOLDOFF: begin
        capture_s = 1'b0;
        push_s    = 1'b0;
      end
      default: begin
        capture_s = 1'b0;
        push_s    = 1'b0;
      end
    endcase
  end

  assign drop_s = push_s && fifo_full_s && !(out_valid && out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_r        <= {TIME_WIDTH{1'b0}};
      peak_r      <= {SIZE_FILTER_DATA{1'b0}};
      peak_time_r <= {TIME_WIDTH{1'b0}};
      holdoff_r   <= {HOLD_W{1'b0}};
      busy_r      <= 1'b0;
      dropped_r   <= 8'd0;
    end else begin
      ts_r   <= ts_r + {{(TIME_WIDTH-1){1'b0}}, 1'b1};
      busy_r <= (state_next_s != ST_IDLE);
      if (capture_s) begin
        peak_r      <= filter_data;
        peak_time_r <= ts_r;
      end
      if (push_s) begin
        holdoff_r <= HOLD_LOAD;
      end else if ((state_r == ST_HOLDOFF) && (holdoff_r != {HOLD_W{1'b0}})) begin
        holdoff_r <= holdoff_r - {{(HOLD_W-1){1'b0}}, 1'b1};
      end
      if (drop_s && (dropped_r != 8'hFF)) begin
        dropped_r <= dropped_r + 8'd1;
      end
    end
  end

  v15_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(event_t))
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_event_s),
    .full      (fifo_full_s),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (head_event_s)
  );

  assign out_amplitude = head_event_s.amplitude;
  assign out_time      = head_event_s.timestamp;
  assign dropped_count = dropped_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_v15_peak_detector.sv
// Directed bench for v15_peak_detector (HOLDOFF 4, FIFO 4, 8-bit timestamps).
module tb_v15_peak_detector;
  import package_settings::*;

  localparam int TW = 8;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic [SIZE_FILTER_DATA-1:0] filter_data = '0;
  logic [SIZE_FILTER_DATA-1:0] threshold = 16'd100;
  logic                        out_ready = 1'b0;
  logic                        out_valid;
  logic [SIZE_FILTER_DATA-1:0] out_amplitude;
  logic [TW-1:0]               out_time;
  logic [7:0]                  dropped_count;
  logic                        busy;

  int checks = 0;
  int errors = 0;
  int ts_b = 0;
  int ev_t [5];
  int t0;

  v15_peak_detector #(
    .HOLDOFF_CYCLES (4),
    .FIFO_DEPTH     (4),
    .TIME_WIDTH     (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .filter_data   (filter_data),
    .threshold     (threshold),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_amplitude (out_amplitude),
    .out_time      (out_time),
    .dropped_count (dropped_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One sample per edge; ts_b is the timestamp the DUT attaches to this sample.
  task automatic step(input int d);
    filter_data = SIZE_FILTER_DATA'(d);
    @(posedge clk);
    #1;
    ts_b = ts_b + 1;
  endtask

  task automatic pulse(input int v, output int t);
    t = ts_b & 255;
    step(v);
    step(0);
    repeat (4) step(0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_amp", out_amplitude, 0);
    check_eq("rst_time", out_time, 0);
    check_eq("rst_dropped", dropped_count, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    ts_b = 0;

    // Basic pulse starting at timestamp 10
    repeat (10) step(0);
    step(0); step(50); step(120);
    check_eq("a_busy_rise", busy, 1);
    step(300); step(300); step(200);
    check_eq("a_no_early_event", out_valid, 0);
    step(90);
    check_eq("a_valid", out_valid, 1);
    check_eq("a_amp", out_amplitude, 300);
    check_eq("a_time", out_time, 13);
    out_ready = 1'b1;
    step(0);
    check_eq("a_popped", out_valid, 0);
    step(0); step(0);
    check_eq("a_holdoff_busy", busy, 1);
    step(0);
    check_eq("a_holdoff_end", busy, 0);

    // Holdoff: early crossing ignored, level re-arm at first IDLE cycle
    t0 = ts_b & 255;
    step(150); step(50);
    check_eq("b_amp1", out_amplitude, 150);
    check_eq("b_time1", out_time, t0);
    step(0); step(200); step(200); step(0); step(0);
    check_eq("b_ignored_busy", busy, 0);
    check_eq("b_ignored_valid", out_valid, 0);
    t0 = ts_b & 255;
    step(180); step(10);
    check_eq("b_amp2", out_amplitude, 180);
    check_eq("b_time2", out_time, t0);
    step(0); step(0); step(220); step(220);
    check_eq("b_holdoff_done", busy, 0);
    t0 = ts_b & 255;
    step(220);
    check_eq("b_rearm_busy", busy, 1);
    step(10);
    check_eq("b_amp3", out_amplitude, 220);
    check_eq("b_time3", out_time, t0);
    repeat (4) step(0);
    check_eq("b_drained", out_valid, 0);

    // Six pulses into a stalled consumer: four kept, two dropped
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int t;
      pulse(110 + 10 * i, t);
      if (i < 4) ev_t[i] = t;
    end
    check_eq("c_dropped", dropped_count, 2);
    check_eq("c_valid_held", out_valid, 1);
    check_eq("c_amp_held", out_amplitude, 110);
    check_eq("c_time_held", out_time, ev_t[0]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("c_pop_amp", out_amplitude, 110 + 10 * i);
      check_eq("c_pop_time", out_time, ev_t[i]);
      step(0);
    end
    check_eq("c_empty", out_valid, 0);

    // Push and pop on the same edge while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int t;
      pulse(200 + i, t);
      ev_t[i] = t;
    end
    ev_t[4] = ts_b & 255;
    step(204);
    out_ready = 1'b1;
    step(0);
    out_ready = 1'b0;
    check_eq("d_no_drop", dropped_count, 2);
    check_eq("d_head_amp", out_amplitude, 201);
    repeat (4) step(0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_eq("d_pop_amp", out_amplitude, 200 + i);
      check_eq("d_pop_time", out_time, ev_t[i]);
      step(0);
    end
    check_eq("d_empty", out_valid, 0);
    out_ready = 1'b0;

    // Threshold raised mid-pulse ends it on the next compare
    t0 = ts_b & 255;
    step(150);
    threshold = 16'd200;
    step(160);
    check_eq("e_valid", out_valid, 1);
    check_eq("e_amp", out_amplitude, 150);
    check_eq("e_time", out_time, t0);
    threshold = 16'd100;
    out_ready = 1'b1;
    repeat (4) step(0);
    check_eq("e_drained", out_valid, 0);
    out_ready = 1'b0;

    // Asynchronous reset during RISE
    pulse(120, t0);
    check_eq("f_pending_amp", out_amplitude, 120);
    step(250);
    check_eq("f_busy", busy, 1);
    reset = 1'b0;
    #2;
    check_eq("f_rst_valid", out_valid, 0);
    check_eq("f_rst_amp", out_amplitude, 0);
    check_eq("f_rst_time", out_time, 0);
    check_eq("f_rst_busy", busy, 0);
    check_eq("f_rst_dropped", dropped_count, 0);
    filter_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ts_b = 0;
    step(0); step(0); step(0);
    check_eq("f_no_event", out_valid, 0);
    check_eq("f_idle", busy, 0);

    // Timestamp wrap: peak at 255, then a pulse peaking at 1
    while (ts_b < 254) step(0);
    step(150); step(190); step(0);
    check_eq("g_amp255", out_amplitude, 190);
    check_eq("g_time255", out_time, 255);
    out_ready = 1'b1;
    while (ts_b < 511) step(0);
    step(150); step(170); step(190); step(0);
    check_eq("g_valid1", out_valid, 1);
    check_eq("g_amp1", out_amplitude, 190);
    check_eq("g_time1", out_time, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/v15_peak_detector.md
V15_PEAK_DETECTOR -- requirements
Module: v15_peak_detector

Interface
REQ-001 Parameter: HOLDOFF_CYCLES, default 16, dead time in clocks after pulse end before re-arming.
REQ-002 Parameter: FIFO_DEPTH, default 4, event buffer entries (power of two).
REQ-003 Parameter: TIME_WIDTH, default 32, timestamp width.
REQ-004 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: filter_data  input  SIZE_FILTER_DATA  shaped filter output, unsigned, one sample per clock.
REQ-007 Port: threshold  input  SIZE_FILTER_DATA  trigger level, unsigned, sampled every clock.
REQ-008 Port: out_ready  input  1  consumer accepts the event when high with out_valid.
REQ-009 Port: out_valid  output  1  FIFO head holds a valid event.
REQ-010 Port: out_amplitude  output  SIZE_FILTER_DATA  peak value of head event.
REQ-011 Port: out_time  output  TIME_WIDTH  timestamp of first sample reaching the peak.
REQ-012 Port: dropped_count  output  8  events lost to a full FIFO, saturating at 255.
REQ-013 Port: busy  output  1  high when FSM is not IDLE.

Function
REQ-014 Free-running timestamp counter SHALL increment by 1 each clock and wrap from 2^TIME_WIDTH-1 to 0.
REQ-015 FSM states SHALL be IDLE, RISE, HOLDOFF.
REQ-016 IDLE -> RISE when filter_data >= threshold; peak <= filter_data, peak_time <= current timestamp.
REQ-017 In RISE, filter_data > peak (strict) SHALL update peak and peak_time; equal values keep the earlier time.
REQ-018 RISE -> HOLDOFF when filter_data < threshold; same edge pushes {peak, peak_time}; holdoff counter <= HOLDOFF_CYCLES-1.
REQ-019 HOLDOFF SHALL decrement each clock, ignore filter_data, and go to IDLE when the counter is 0.
REQ-020 HOLDOFF_CYCLES=0 SHALL be illegal; 1 gives one HOLDOFF clock.
REQ-021 Samples >= threshold on the first IDLE cycle after HOLDOFF SHALL start a new RISE (level re-arm, no edge needed).
REQ-022 Threshold changes during RISE SHALL take effect on the next sample compare.
REQ-023 Event SHALL appear on out_* one clock after the push edge when the FIFO was empty.
REQ-024 Transfer occurs on posedge with out_valid & out_ready; out_* SHALL hold stable while out_valid & !out_ready.
REQ-025 Push to a full FIFO with no pop that cycle SHALL drop the new event and increment dropped_count (saturating).
REQ-026 Simultaneous push and pop on a full FIFO SHALL accept the push; count stays FIFO_DEPTH.
REQ-027 Simultaneous push and pop on an empty FIFO cannot occur (out_valid low); push only.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra count bit.
REQ-029 All outputs SHALL be registered; no combinational path from filter_data to out_*.

Reset
REQ-030 reset low SHALL asynchronously force: FSM IDLE, timestamp 0, peak 0, FIFO empty, out_valid 0, out_amplitude 0, out_time 0, dropped_count 0, busy 0.
REQ-031 Reset mid-RISE SHALL discard the in-progress pulse with no event emitted.
REQ-032 First active edge after reset release SHALL treat state as IDLE with timestamp 0.

Structure
REQ-033 Package v15_peak_parameters SHALL hold HOLDOFF_CYCLES, FIFO_DEPTH and TIME_WIDTH defaults, the state enum typedef and the event struct typedef {amplitude, time}; SIZE_FILTER_DATA comes from package_settings.
REQ-034 The event buffer SHALL be sub-module v15_event_fifo (parameterised depth, valid/ready read side, push/full write side).

Verification
REQ-035 Threshold 100; samples 0,50,120,300,300,200,90 from timestamp 10 -> one event amplitude 300, time 13, out_valid at the cycle after the 90 sample.
REQ-036 HOLDOFF_CYCLES 4; second pulse crossing threshold 2 clocks after first falls -> ignored; crossing 5 clocks after -> second event emitted.
REQ-037 out_ready held 0, six pulses -> first four events retained in order, dropped_count 2; then out_ready 1 -> four transfers, out_valid low afterwards.
REQ-038 FIFO full, out_ready 1 on the same edge as a push -> no drop, count stays 4, FIFO order preserved.
REQ-039 reset asserted mid-RISE (peak 250) -> outputs zero immediately without clock; after release no event for that pulse.
REQ-040 Timestamp preloaded near wrap (TIME_WIDTH 8, pulse peaking at 255 then 1) -> reported time 255 vs 1 matches the peak sample.
